pulse_stretch: RTL and testbench

PULSE_STRETCH -- requirements
Module: pulse_stretch

---
 rtl/clock_common_pkg.sv | 13 +
 rtl/cycle_timer.sv | 38 +++
 rtl/pulse_stretch.sv | 159 +++++++++++++++
 tb/tb_pulse_stretch.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_common_pkg.sv
// Shared timing-block constants: FSM state encodings and counter width.
// Latency: n/a (constants only).
// Backpressure: n/a.
package clock_common_pkg;

  localparam int CNT_W = 16;

  // Legacy-compatible state encodings used by the stretch/toggle FSM.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Latency: load takes effect on the next edge; counts down one per cycle, stops at 0.
// Backpressure: none; load always wins over counting.
module cycle_timer
  import clock_common_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: reload on request, otherwise decrement until zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register, cleared by asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Stretches single-cycle pulses to HOLD_CYCLES highs separated by GAP_CYCLES lows, or toggles a level per pulse.
// Latency: level_out responds on the edge after the pulse_in cycle; all outputs registered.
// Backpressure: none upstream; extra pulses queue in a saturating counter, overflow is flagged sticky.
module pulse_stretch
  import clock_common_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  input  logic              mode,
  input  logic              clr_ovf,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              ovf
);

  localparam logic [CNT_W-1:0]  HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  logic [1:0]        state_q, state_d;
  logic              mode_q, mode_d;
  logic              tog_q, tog_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              level_q, level_d;
  logic              busy_q, busy_d;

  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_done;
  logic              mode_eff;
  logic              inc, dec, ovf_set;

  cycle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // FSM, mode latch, toggle register, pending queue and overflow next-state.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    tog_d    = tog_q;
    pend_d   = pend_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    inc      = 1'b0;
    dec      = 1'b0;
    ovf_set  = 1'b0;

    // A pulse in the same IDLE cycle as a mode change obeys the new mode.
    mode_eff = (state_q == IDLE) ? mode : mode_q;
    if (state_q == IDLE) begin
      mode_d = mode;
    end

    case (state_q)
      IDLE: begin
        if (pulse_in) begin
          if (mode_eff) begin
            tog_d = ~tog_q;
          end else begin
            state_d  = HIGH;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LD;
          end
        end
      end
      HIGH: begin
        inc = pulse_in;
        if (tmr_done) begin
          state_d  = GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
      end
      GAP: begin
        if (tmr_done) begin
          if (pend_q != '0) begin
            // Queued pulse starts now; a new pulse queues behind it.
            state_d  = HIGH;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LD;
            dec      = 1'b1;
            inc      = pulse_in;
          end else if (pulse_in) begin
            // Pulse on the last gap cycle is consumed directly.
            state_d  = HIGH;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          inc = pulse_in;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Leaving toggle mode restarts the toggle level from zero.
    if (mode_q && !mode_d) begin
      tog_d = 1'b0;
    end

    if (inc && !dec) begin
      if (pend_q == PEND_MAX) begin
        ovf_set = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (dec && !inc) begin
      pend_d = pend_q - PEND_W'(1);
    end

    // Set beats clear when both happen together.
    ovf_d   = ovf_set | (ovf_q & ~clr_ovf);
    level_d = mode_d ? tog_d : (state_d == HIGH);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers, all cleared by asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      tog_q   <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tog_q   <= tog_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  assign level_out = level_q;
  assign busy      = busy_q;
  assign pending   = pend_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Scoreboard bench for pulse_stretch: stimulus pushes hand-derived per-cycle expectations, monitor pops and compares.
// Latency: expectations are indexed by cycle; outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_pulse_stretch;

  logic       clk;
  logic       rst;
  logic       pulse_in;
  logic       mode;
  logic       clr_ovf;
  logic       level_out;
  logic       busy;
  logic [2:0] pending;
  logic       ovf;

  pulse_stretch #(
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (2),
    .PEND_W      (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pulse_in  (pulse_in),
    .mode      (mode),
    .clr_ovf   (clr_ovf),
    .level_out (level_out),
    .busy      (busy),
    .pending   (pending),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    int         cyc;
    logic       lvl;
    logic       bsy;
    logic [2:0] pnd;
    logic       ov;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Case description, filled in before each run.
  int pulses[$];
  int clrs[$];
  int lvl_lo[$], lvl_hi[$];
  int bsy_lo[$], bsy_hi[$];
  int pc[$], pv[$];
  int ovf_on, ovf_off;
  int mode_lo, mode_hi;
  int rst_lo, rst_hi;

  function automatic bit member(int q[$], int c);
    foreach (q[i]) if (q[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit in_rng(int lo[$], int hi[$], int c);
    foreach (lo[i]) if (c >= lo[i] && c <= hi[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pend_at(int c);
    int v = 0;
    foreach (pc[i]) if (pc[i] <= c) v = pv[i];
    return v;
  endfunction

  task automatic chk(string nm, int cyc, string fld, int act, int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s c%0d %s: got %0d want %0d", nm, cyc, fld, act, want);
    end
  endtask

  task automatic clear_case();
    pulses = {}; clrs = {};
    lvl_lo = {}; lvl_hi = {};
    bsy_lo = {}; bsy_hi = {};
    pc = {}; pv = {};
    ovf_on = -1; ovf_off = -1;
    mode_lo = -1; mode_hi = -1;
    rst_lo = -1; rst_hi = -1;
  endtask

  // Drive one case; cycles 0-1 are always in reset.
  task automatic run_case(string nm, int len);
    exp_t e;
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
      rst      = (c < 2) || (c >= rst_lo && c <= rst_hi);
      pulse_in = member(pulses, c);
      mode     = (c >= mode_lo && c < mode_hi);
      clr_ovf  = member(clrs, c);
      e.nm  = nm;
      e.cyc = c;
      if (rst) begin
        e.lvl = 1'b0; e.bsy = 1'b0; e.pnd = 3'd0; e.ov = 1'b0;
      end else begin
        e.lvl = in_rng(lvl_lo, lvl_hi, c);
        e.bsy = in_rng(bsy_lo, bsy_hi, c);
        e.pnd = 3'(pend_at(c));
        e.ov  = (c >= ovf_on && c < ovf_off);
      end
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compare the DUT outputs against each queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.nm, e.cyc, "level_out", int'(level_out), int'(e.lvl));
        chk(e.nm, e.cyc, "busy",      int'(busy),      int'(e.bsy));
        chk(e.nm, e.cyc, "pending",   int'(pending),   int'(e.pnd));
        chk(e.nm, e.cyc, "ovf",       int'(ovf),       int'(e.ov));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pulse_in = 1'b0; mode = 1'b0; clr_ovf = 1'b0;

    // Single pulse.
    clear_case();
    pulses = '{10};
    lvl_lo = '{11}; lvl_hi = '{14};
    bsy_lo = '{11}; bsy_hi = '{16};
    run_case("single", 20);

    // Queued pulses.
    clear_case();
    pulses = '{10, 12, 13};
    lvl_lo = '{11, 17, 23}; lvl_hi = '{14, 20, 26};
    bsy_lo = '{11}; bsy_hi = '{28};
    pc = '{13, 14, 17, 23}; pv = '{1, 2, 1, 0};
    run_case("queued", 32);

    // Pulse on last gap cycle with nothing queued.
    clear_case();
    pulses = '{10, 16};
    lvl_lo = '{11, 17}; lvl_hi = '{14, 20};
    bsy_lo = '{11}; bsy_hi = '{22};
    run_case("gapend", 26);

    // Pulse on last gap cycle with one queued: pending holds at 1.
    clear_case();
    pulses = '{10, 12, 16};
    lvl_lo = '{11, 17, 23}; lvl_hi = '{14, 20, 26};
    bsy_lo = '{11}; bsy_hi = '{28};
    pc = '{13, 23}; pv = '{1, 0};
    run_case("gapend_q", 32);

    // Saturation, set beats clear at 19, later clear at 66.
    clear_case();
    pulses = '{10, 11, 12, 13, 14, 15, 16, 17, 18, 19};
    for (int k = 0; k < 9; k++) begin
      lvl_lo.push_back(11 + 6 * k);
      lvl_hi.push_back(14 + 6 * k);
    end
    bsy_lo = '{11}; bsy_hi = '{64};
    pc = '{12, 13, 14, 15, 16, 18, 19, 23, 29, 35, 41, 47, 53, 59};
    pv = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};
    clrs = '{19, 66};
    ovf_on = 20; ovf_off = 67;
    run_case("saturate", 70);

    // Toggle mode entered with a pulse in the same cycle, then back to stretch with a pulse.
    clear_case();
    mode_lo = 5; mode_hi = 13;
    pulses = '{5, 9, 10, 13};
    lvl_lo = '{6, 11}; lvl_hi = '{9, 17};
    bsy_lo = '{14}; bsy_hi = '{19};
    run_case("toggle", 24);

    // Reset mid-operation discards queued work.
    clear_case();
    pulses = '{10, 12, 13};
    rst_lo = 12; rst_hi = 13;
    lvl_lo = '{11}; lvl_hi = '{11};
    bsy_lo = '{11}; bsy_hi = '{11};
    run_case("reset", 30);

    @(negedge clk);
    @(negedge clk);
    chk("end", 0, "queue_left", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
